// File: rtl/seq_pkg.sv
// Shared definitions for the 0-3-5-7-2-1-0 sequence: states, symbols,
// the successor function and the illegal-value predicate.
package seq_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S5 = 3'd5;
  localparam logic [2:0] S7 = 3'd7;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S1 = 3'd1;

  function automatic logic [2:0] nxt(input logic [2:0] v);
    logic [2:0] r;
    r = S0;
    unique case (1'b1)
      (v == S0): r = S3;
      (v == S3): r = S5;
      (v == S5): r = S7;
      (v == S7): r = S2;
      (v == S2): r = S1;
      (v == S1): r = S0;
      default:   r = S0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic [2:0] v);
    return (v == 3'd4) || (v == 3'd6);
  endfunction

endpackage

// File: rtl/seq_next_lut.sv
// Combinational successor lookup: val -> {succ, legal}.
// Shared with the sequence generators.
module seq_next_lut
  import seq_pkg::*;
(
  input  logic [2:0] val,
  output logic [2:0] succ,
  output logic       legal
);

  assign succ  = nxt(val);
  assign legal = !is_illegal(val);

endmodule

// File: rtl/seq_checker.sv
// Receive-side checker for the 0-3-5-7-2-1-0 counter sequence.
// Optional macro SEQ_CHECKER_RESYNC_EN realigns on legal locked mismatches.
module seq_checker
  import seq_pkg::*;
#(
  parameter int LOCK_LEN = 4,
  parameter int LOSS_THR = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [2:0]       din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err,
  output logic             illegal,
  output logic [2:0]       expected,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] seq_count
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);
  localparam logic [3:0] LOSS_N = 4'(LOSS_THR);

  state_t     state;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;

  logic [2:0] din_nxt;
  logic       din_legal;
  logic [2:0] exp_nxt;
  logic       exp_legal;
  logic [2:0] miss_exp;

  seq_next_lut u_din_lut (
    .val   (din),
    .succ  (din_nxt),
    .legal (din_legal)
  );

  seq_next_lut u_exp_lut (
    .val   (expected),
    .succ  (exp_nxt),
    .legal (exp_legal)
  );

`ifdef SEQ_CHECKER_RESYNC_EN
  assign miss_exp = din_legal ? din_nxt : exp_nxt;
`else
  assign miss_exp = exp_nxt;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      err       <= 1'b0;
      illegal   <= 1'b0;
      expected  <= S0;
      err_count <= '0;
      seq_count <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      err     <= 1'b0;
      illegal <= 1'b0;
      if (din_valid) begin
        illegal <= !din_legal;
        unique case (state)
          SEARCH: begin
            if (din == S0) begin
              state     <= VERIFY;
              expected  <= S3;
              match_cnt <= '0;
            end else begin
              expected <= S0;
            end
          end
          VERIFY: begin
            if (din == expected) begin
              match_cnt <= match_cnt + 4'd1;
              expected  <= din_nxt;
              if (match_cnt + 4'd1 == LOCK_N) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (din == S0) begin
              expected  <= S3;
              match_cnt <= '0;
            end else begin
              state    <= SEARCH;
              expected <= S0;
            end
          end
          LOCKED: begin
            if (din == expected) begin
              expected <= din_nxt;
              miss_cnt <= '0;
              if (din == S0)
                seq_count <= seq_count + CNT_W'(1);
            end else begin
              err <= 1'b1;
              if (err_count != '1)
                err_count <= err_count + CNT_W'(1);
              // Losing lock overrides any realignment
              if (miss_cnt + 4'd1 == LOSS_N) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                expected <= S0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
                expected <= miss_exp;
              end
            end
          end
          default: begin
            state    <= SEARCH;
            locked   <= 1'b0;
            expected <= S0;
          end
        endcase
      end
    end
  end

  logic unused_exp_legal;
  assign unused_exp_legal = exp_legal;

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Receive-side checker for the 3-bit 0-3-5-7-2-1-0 counting sequence produced by our synchronous sequence counter.
- Samples the counter value and searches for sequence alignment, then declares lock and flags every symbol that breaks the sequence.
- Keeps saturating error and completed-cycle counters.
- Sits at the consumer end of the counter bus, for example in a link or bench monitor.

Parameters:
- LOCK_LEN, 4: number of consecutive correct transitions after a 0 that are required to declare lock (range 1..15).
- LOSS_THR, 3: number of consecutive mismatches while locked that drop lock (range 1..15).
- CNT_W, 8: width of err_count and seq_count.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- clr  input  1  asynchronous, active-high reset.
- din  input  3  received sequence value.
- din_valid  input  1  qualifies din; when low, all state holds and no pulses are generated.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse for a mismatch while LOCKED.
- illegal  output  1  one-cycle pulse when a valid din is 4 or 6, in any state.
- expected  output  3  next value the block expects.
- err_count  output  CNT_W  saturating count of LOCKED mismatches.
- seq_count  output  CNT_W  wrapping count of completed sequences while LOCKED.

Behaviour:
- Reset: clr=1 forces state=SEARCH, locked=0, err=0, illegal=0, expected=0, err_count=0, seq_count=0, and clears the internal match_cnt and miss_cnt. Reset is asynchronous and takes effect immediately, including mid-operation.
- Successor function: nxt(0)=3, nxt(3)=5, nxt(5)=7, nxt(7)=2, nxt(2)=1, nxt(1)=0. Values 4 and 6 are illegal, and nxt of an illegal value is 0.
- Latency: all outputs are registered and reflect the din sampled at the previous rising edge. err and illegal are high for exactly one cycle per offending sample.
- SEARCH state, on a valid din:
  - din=0: go to VERIFY, expected=3, match_cnt=0.
  - anything else: stay in SEARCH, expected=0.
- VERIFY state, on a valid din:
  - din==expected: match_cnt+1; expected=nxt(din). If match_cnt+1==LOCK_LEN, go to LOCKED and set miss_cnt=0.
  - Mismatch with din=0: restart alignment, stay in VERIFY, expected=3, match_cnt=0.
  - Any other mismatch: go to SEARCH, expected=0.
  - No err pulse and no err_count change occur in VERIFY.
- LOCKED state, on a valid din:
  - Match: expected=nxt(din), miss_cnt=0. If din==0, seq_count increments (wraps at 2^CNT_W).
  - Mismatch: err pulses, err_count increments (saturating at all-ones), miss_cnt+1, expected=nxt(expected).
  - If miss_cnt+1==LOSS_THR: go to SEARCH, locked=0, expected=0, and the err pulse for that sample still fires.
- Simultaneous events: an illegal value while LOCKED raises both err and illegal. err_count saturation does not affect state transitions. din_valid=0 on any cycle is a pure stall.

Optional Feature:
- Macro: SEQ_CHECKER_RESYNC_EN.
- When defined, a LOCKED mismatch with a legal din realigns the checker: expected=nxt(din). This lets a single skipped or repeated symbol cost only one error.
- When defined, an illegal din still uses expected=nxt(expected).
- When undefined, a mismatch always sets expected=nxt(expected).
- Error counting, miss_cnt and loss-of-lock behaviour are identical with and without the macro.

Decomposition:
- Package seq_pkg holds:
  - the state enum {SEARCH, VERIFY, LOCKED};
  - the 3-bit symbol constants S0, S3, S5, S7, S2, S1;
  - the successor function nxt and the illegal-value predicate.
- Sub-module seq_next_lut: purely combinational, mapping a 3-bit value to {successor[2:0], legal}. It is shared with future sequence generators.
- seq_checker holds the FSM, counters and output registers.

Test Plan:
- Lock: after clr release, feed valid 0,3,5,7,2 with LOCK_LEN=4. locked rises one cycle after 2 is sampled, and expected=1.
- Single error, macro off: while locked with expected=5, feed 6,7,2. err and illegal pulse once, err_count=1, expected=7 after the 6, then the 7 and 2 match and locked stays 1.
- Resync, macro on: while locked with expected=5, feed 7. err pulses, expected=2, and the following 2,1,0 match with no further err. seq_count increments on the 0.
- Loss of lock: LOSS_THR=3, while locked feed 1,1,1 against expected 5. Three err pulses occur and locked falls after the third. A following stream 3,5 keeps the block in SEARCH; a 0 moves it to VERIFY.
- Saturation: CNT_W=4, while locked alternate one wrong and one correct symbol for 20 errors. err_count stops at 15, locked stays 1, and seq_count keeps advancing.
- Reset mid-operation and stall: assert clr while locked with err_count=5; all outputs go to 0 immediately. Separately, din_valid=0 for 10 cycles with garbage din leaves all outputs unchanged.
